mybus_rx_deser: RTL and testbench

//  Always-on receive stage downstream of the MyBus execute/dataTx producers (Stage6/Stage7 domains).

---
 rtl/mybus_pkg.sv | 7 +
 rtl/mybus_rx_fifo.sv | 40 ++++
 rtl/mybus_rx_deser.sv | 101 ++++++++++
 tb/tb_mybus_rx_deser.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mybus_pkg.sv
// mybus_pkg: shared receive-path types and default sizing for the MyBus deserialiser.
package mybus_pkg;
    typedef enum logic {IDLE, SHIFT} rx_state_e;
    localparam int MYBUS_WORD_W     = 8;
    localparam int MYBUS_RX_TIMEOUT = 15;
    localparam int MYBUS_RX_DEPTH   = 2;
endpackage

// File: rtl/mybus_rx_fifo.sv
// mybus_rx_fifo: synchronous word FIFO; pointers carry a wrap bit to tell full from empty.
module mybus_rx_fifo
    import mybus_pkg::*;
#(
    parameter int DEPTH = MYBUS_RX_DEPTH,
    parameter int W     = MYBUS_WORD_W
) (
    input  logic         ck,
    input  logic         arst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wr, rd;
    logic [W-1:0] mem [DEPTH];
    logic         pop_ok, push_ok;
    assign empty   = wr == rd;
    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign head    = mem[rd[AW-1:0]];
    assign pop_ok  = pop && !empty;
    // a pop on the same edge frees the slot a full FIFO would otherwise refuse
    assign push_ok = push && (!full || pop_ok);
    always_ff @(posedge ck) begin
        if (!arst) begin
            wr <= '0;
            rd <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr[AW-1:0]] <= din;
                wr <= wr + 1'b1;
            end
            if (pop_ok) rd <= rd + 1'b1;
        end
    end
endmodule

// File: rtl/mybus_rx_deser.sv
// mybus_rx_deser: LSB-first serial-to-word receiver with gap timeout, isolation discard
// and a small output FIFO behind valid/ready.
module mybus_rx_deser
    import mybus_pkg::*;
#(
    parameter int WIDTH      = MYBUS_WORD_W,
    parameter int TIMEOUT    = MYBUS_RX_TIMEOUT,
    parameter int FIFO_DEPTH = MYBUS_RX_DEPTH
) (
    input  logic             ck,
    input  logic             arst,
    input  logic             isolate_src,
    input  logic             execute,
    input  logic             data_tx,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             busy,
    output logic             overflow_o,
    output logic             timeout_o
);
    localparam int CW = $clog2(WIDTH);
    localparam int GW = $clog2(TIMEOUT + 1);
    rx_state_e        state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [GW-1:0]    gap, gap_n;
    logic [WIDTH-2:0] sreg, sreg_n;
    logic             done, abort, push_q, full, empty;
    logic [WIDTH-1:0] push_word;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gap_n   = gap;
        sreg_n  = sreg;
        done    = 1'b0;
        abort   = 1'b0;
        if (isolate_src) begin
            state_n = IDLE;
            cnt_n   = '0;
            gap_n   = '0;
        end else if (state == IDLE) begin
            if (execute) begin
                sreg_n[0] = data_tx;
                cnt_n     = CW'(1);
                gap_n     = '0;
                state_n   = SHIFT;
            end
        end else if (execute) begin
            gap_n = '0;
            if (cnt == CW'(WIDTH - 1)) begin
                done    = 1'b1;
                cnt_n   = '0;
                state_n = IDLE;
            end else begin
                sreg_n[cnt] = data_tx;
                cnt_n       = cnt + CW'(1);
            end
        end else if (gap == GW'(TIMEOUT - 1)) begin
            abort   = 1'b1;
            cnt_n   = '0;
            gap_n   = '0;
            state_n = IDLE;
        end else begin
            gap_n = gap + GW'(1);
        end
    end
    // completed word is pushed one edge later; overflow is judged at that push edge
    always_ff @(posedge ck) begin
        if (!arst) begin
            state      <= IDLE;
            cnt        <= '0;
            gap        <= '0;
            sreg       <= '0;
            push_q     <= 1'b0;
            push_word  <= '0;
            overflow_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            gap        <= gap_n;
            sreg       <= sreg_n;
            push_q     <= done;
            push_word  <= {data_tx, sreg};
            overflow_o <= push_q && full && !word_ready;
            timeout_o  <= abort;
        end
    end
    assign busy       = state == SHIFT;
    assign word_valid = !empty;
    mybus_rx_fifo #(.DEPTH(FIFO_DEPTH), .W(WIDTH)) u_fifo (
        .ck    (ck),
        .arst  (arst),
        .push  (push_q),
        .din   (push_word),
        .pop   (word_ready),
        .full  (full),
        .empty (empty),
        .head  (word_o)
    );
endmodule

// File: tb/tb_mybus_rx_deser.sv
// tb_mybus_rx_deser: directed vector table, corner sequences and random traffic vs a queue-based model.
module tb_mybus_rx_deser;
    localparam int W  = 8;
    localparam int TO = 15;
    localparam int D  = 2;
    logic         ck = 1'b0;
    logic         arst, isolate_src, execute, data_tx, word_ready;
    logic [W-1:0] word_o;
    logic         word_valid, busy, overflow_o, timeout_o;
    int checks = 0, errors = 0, n_ovf = 0, n_tmo = 0;
    bit           bits[$];
    logic [W-1:0] fq[$];
    logic [W-1:0] got[$];
    int           gap = 0;
    bit           pend = 0, m_ovf = 0, m_tmo = 0;
    logic [W-1:0] pend_word;
    typedef struct {
        logic rst_n, iso, ex, d, rdy;
        logic e_valid;
        logic [W-1:0] e_word;
        logic e_busy, e_ovf, e_tmo;
    } vec_t;
    vec_t tv[12];
    mybus_rx_deser #(.WIDTH(W), .TIMEOUT(TO), .FIFO_DEPTH(D)) dut (
        .ck          (ck),
        .arst        (arst),
        .isolate_src (isolate_src),
        .execute     (execute),
        .data_tx     (data_tx),
        .word_o      (word_o),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .busy        (busy),
        .overflow_o  (overflow_o),
        .timeout_o   (timeout_o)
    );
    always #5 ck = ~ck;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    function automatic logic [W-1:0] gw(input int k);
        return (k < got.size()) ? got[k] : 'x;
    endfunction
    // frame rules applied to queues: bits collected so far, FIFO contents, one pending word
    task automatic model_edge(input logic r, i, e, d, y);
        bit pop, acc;
        if (!r) begin
            bits.delete(); fq.delete();
            gap = 0; pend = 0; m_ovf = 0; m_tmo = 0;
            return;
        end
        m_ovf = 0; m_tmo = 0;
        pop = y && fq.size() > 0;
        acc = pend && (fq.size() < D || pop);
        if (pop) void'(fq.pop_front());
        if (pend) begin
            if (acc) fq.push_back(pend_word);
            else m_ovf = 1;
        end
        pend = 0;
        if (i) begin
            bits.delete(); gap = 0;
        end else if (e) begin
            bits.push_back(d); gap = 0;
            if (bits.size() == W) begin
                pend_word = '0;
                foreach (bits[k]) pend_word = pend_word + (W'(bits[k]) << k);
                pend = 1;
                bits.delete();
            end
        end else if (bits.size() > 0) begin
            gap++;
            if (gap == TO) begin
                bits.delete(); gap = 0; m_tmo = 1;
            end
        end
    endtask
    task automatic step(input logic r, i, e, d, y);
        arst = r; isolate_src = i; execute = e; data_tx = d; word_ready = y;
        if (word_valid === 1'b1 && y && r) got.push_back(word_o);
        @(posedge ck);
        model_edge(r, i, e, d, y);
        #1;
        chk("word_valid", word_valid, fq.size() > 0);
        chk("busy", busy, bits.size() > 0);
        chk("overflow_o", overflow_o, m_ovf);
        chk("timeout_o", timeout_o, m_tmo);
        chk("pulse_excl", overflow_o & timeout_o, 0);
        if (fq.size() > 0) chk("word_o", word_o, fq[0]);
        n_ovf += overflow_o;
        n_tmo += timeout_o;
    endtask
    task automatic send(input logic [W-1:0] w, input logic y);
        for (int k = 0; k < W; k++) step(1, 0, 1, w[k], y);
    endtask
    task automatic idle(input int n, input logic y);
        repeat (n) step(1, 0, 0, 1'($urandom), y);
    endtask
    initial begin
        logic [W-1:0] pat;
        int mode;
        pat = 8'h4D;
        tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++)
            tv[i+1] = '{1'b1, 1'b0, 1'b1, pat[i], 1'b1, 1'b0, 8'h00, (i < 7) ? 1'b1 : 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h4D, 1'b0, 1'b0, 1'b0};
        tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tv[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        for (int r = 0; r < 12; r++) begin
            step(tv[r].rst_n, tv[r].iso, tv[r].ex, tv[r].d, tv[r].rdy);
            chk("tv_valid", word_valid, tv[r].e_valid);
            chk("tv_busy", busy, tv[r].e_busy);
            chk("tv_ovf", overflow_o, tv[r].e_ovf);
            chk("tv_tmo", timeout_o, tv[r].e_tmo);
            if (tv[r].e_valid || !tv[r].rst_n) chk("tv_word", word_o, tv[r].e_word);
        end
        chk("t1_pops", got.size(), 1);
        chk("t1_word", gw(0), 8'h4D);
        got.delete();
        n_ovf = 0;
        send(8'hA5, 0); send(8'h3C, 0); send(8'hFF, 0);
        idle(2, 0);
        chk("t2_ovf_count", n_ovf, 1);
        chk("t2_valid", word_valid, 1);
        idle(3, 1);
        chk("t2_pops", got.size(), 2);
        chk("t2_w0", gw(0), 8'hA5);
        chk("t2_w1", gw(1), 8'h3C);
        got.delete();
        n_tmo = 0;
        for (int k = 0; k < 4; k++) step(1, 0, 1, 1'(k), 1);
        idle(14, 1);
        chk("t3_no_early_tmo", n_tmo, 0);
        chk("t3_busy_before", busy, 1);
        idle(1, 1);
        chk("t3_tmo_count", n_tmo, 1);
        chk("t3_busy", busy, 0);
        send(8'h81, 1); idle(2, 1);
        chk("t3_pops", got.size(), 1);
        chk("t3_word", gw(0), 8'h81);
        got.delete();
        n_ovf = 0; n_tmo = 0;
        for (int k = 0; k < 5; k++) step(1, 0, 1, 1'(k + 1), 1);
        repeat (3) step(1, 1, 1, 1'($urandom), 1);
        chk("t4_busy", busy, 0);
        chk("t4_valid", word_valid, 0);
        chk("t4_pulses", n_ovf + n_tmo, 0);
        send(8'h5A, 1); idle(2, 1);
        chk("t4_pops", got.size(), 1);
        chk("t4_word", gw(0), 8'h5A);
        got.delete();
        n_ovf = 0;
        send(8'h11, 0); send(8'h22, 0); idle(1, 0);
        send(8'h33, 0);
        step(1, 0, 0, 0, 1);
        idle(1, 0);
        chk("t5_ovf", n_ovf, 0);
        idle(3, 1);
        chk("t5_pops", got.size(), 3);
        chk("t5_w0", gw(0), 8'h11);
        chk("t5_w1", gw(1), 8'h22);
        chk("t5_w2", gw(2), 8'h33);
        got.delete();
        send(8'h44, 0); idle(1, 0);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 0);
        chk("t6_valid", word_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_pulses", overflow_o | timeout_o, 0);
        send(8'h96, 1); idle(2, 1);
        chk("t6_pops", got.size(), 1);
        chk("t6_word", gw(0), 8'h96);
        got.delete();
        mode = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) mode = $urandom_range(0, 3);
            step(($urandom % 500) != 0, ($urandom % 40) == 0,
                 (mode != 0) && (($urandom % 4) != 0), 1'($urandom), 1'($urandom));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
